avalon_line_writer: RTL and testbench

AVALON_LINE_WRITER -- requirements
Module: avalon_line_writer

---
 rtl/avalon_line_writer_pkg.sv | 15 +
 rtl/avalon_line_writer_credit.sv | 38 +++
 rtl/avalon_line_writer.sv | 158 +++++++++++++++
 tb/tb_avalon_line_writer.sv | 362 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/avalon_line_writer_pkg.sv
// Shared types and constants for the Avalon line writer.
package avalon_line_writer_pkg;

    typedef enum logic [1:0] {
        StIdle  = 2'd0,
        StIssue = 2'd1,
        StDrain = 2'd2,
        StDone  = 2'd3
    } state_e;

    localparam logic [1:0] RespOkay      = 2'b00;
    localparam logic [1:0] RespSlaveErr  = 2'b10;
    localparam int unsigned LaneWidth    = 64;

endpackage

// File: rtl/avalon_line_writer_credit.sv
// Up/down counter of bursts awaiting a write response, with full/empty flags.
module avalon_line_writer_credit #(
    parameter int unsigned MaxCount = 8
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic inc_i,
    input  logic dec_i,
    output logic full_o,
    output logic empty_o
);

    localparam int unsigned CntWidth = $clog2(MaxCount + 1);

    logic [CntWidth-1:0] count_q, count_d;

    // Simultaneous inc/dec cancel; a decrement at zero is dropped (reported by the parent).
    always_comb begin
        count_d = count_q;
        if (inc_i && !dec_i && !full_o) begin
            count_d = count_q + CntWidth'(1);
        end else if (dec_i && !inc_i && !empty_o) begin
            count_d = count_q - CntWidth'(1);
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign full_o  = (count_q == CntWidth'(MaxCount));
    assign empty_o = (count_q == '0);

endmodule

// File: rtl/avalon_line_writer.sv
// Streams a seeded data pattern to consecutive host lines as Avalon-MM write bursts,
// bounding the number of bursts that may await a write response.
module avalon_line_writer
    import avalon_line_writer_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH      = 42,
    parameter int unsigned DATA_WIDTH      = 512,
    parameter int unsigned MAX_BURST       = 4,
    parameter int unsigned MAX_OUTSTANDING = 8,
    localparam int unsigned BcWidth        = $clog2(MAX_BURST) + 1
) (
    input  logic                    clk,
    input  logic                    reset_n,
    input  logic                    start,
    input  logic [ADDR_WIDTH-1:0]   start_addr,
    input  logic [15:0]             num_lines,
    input  logic [63:0]             seed,
    output logic                    busy,
    output logic                    done,
    output logic                    error,
    output logic [15:0]             lines_written,
    output logic                    wr_write,
    output logic [ADDR_WIDTH-1:0]   wr_address,
    output logic [BcWidth-1:0]      wr_burstcount,
    output logic [DATA_WIDTH-1:0]   wr_writedata,
    output logic [DATA_WIDTH/8-1:0] wr_byteenable,
    input  logic                    wr_waitrequest,
    input  logic                    wr_writeresponsevalid,
    input  logic [1:0]              wr_writeresponse
);

    state_e                state_q, state_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [15:0]           num_q, num_d;
    logic [63:0]           seed_q, seed_d;
    logic [15:0]           lines_q, lines_d;
    logic [BcWidth-1:0]    beats_left_q, beats_left_d;
    logic [BcWidth-1:0]    len_q, len_d;
    logic                  error_q, error_d;

    logic [15:0]        remaining;
    logic [BcWidth-1:0] first_len, cur_len;
    logic               in_burst, accept, burst_first, last_of_burst, resp_bad;
    logic               credit_full, credit_empty;
    logic [63:0]        line_word;

    // Beats still owed in the open burst; zero means the next beat opens a new burst.
    assign in_burst  = (beats_left_q != '0);
    assign remaining = num_q - lines_q;
    assign first_len = (remaining >= 16'(MAX_BURST)) ? BcWidth'(MAX_BURST) : BcWidth'(remaining);
    assign cur_len   = in_burst ? len_q : first_len;

    assign wr_write      = (state_q == StIssue) && (in_burst || !credit_full);
    assign accept        = wr_write && !wr_waitrequest;
    assign burst_first   = accept && !in_burst;
    assign last_of_burst = accept && (in_burst ? (beats_left_q == BcWidth'(1))
                                               : (first_len == BcWidth'(1)));
    assign resp_bad      = wr_writeresponsevalid &&
                           ((wr_writeresponse != RespOkay) || credit_empty);

    always_comb begin
        state_d      = state_q;
        addr_d       = addr_q;
        num_d        = num_q;
        seed_d       = seed_q;
        lines_d      = lines_q;
        beats_left_d = beats_left_q;
        len_d        = len_q;
        error_d      = error_q;

        unique case (state_q)
            StIdle: begin
                if (start) begin
                    addr_d       = start_addr;
                    num_d        = num_lines;
                    seed_d       = seed;
                    lines_d      = '0;
                    beats_left_d = '0;
                    error_d      = 1'b0;
                    state_d      = (num_lines == '0) ? StDone : StIssue;
                end
            end
            StIssue: begin
                if (accept) begin
                    lines_d      = lines_q + 16'd1;
                    len_d        = cur_len;
                    beats_left_d = (in_burst ? beats_left_q : first_len) - BcWidth'(1);
                    if (last_of_burst) begin
                        addr_d = addr_q + ADDR_WIDTH'(cur_len);
                    end
                    if (lines_q + 16'd1 == num_q) begin
                        state_d = StDrain;
                    end
                end
            end
            StDrain: begin
                if (credit_empty) begin
                    state_d = StDone;
                end
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase

        if (resp_bad) begin
            error_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= StIdle;
            addr_q       <= '0;
            num_q        <= '0;
            seed_q       <= '0;
            lines_q      <= '0;
            beats_left_q <= '0;
            len_q        <= '0;
            error_q      <= 1'b0;
        end else begin
            state_q      <= state_d;
            addr_q       <= addr_d;
            num_q        <= num_d;
            seed_q       <= seed_d;
            lines_q      <= lines_d;
            beats_left_q <= beats_left_d;
            len_q        <= len_d;
            error_q      <= error_d;
        end
    end

    avalon_line_writer_credit #(
        .MaxCount(MAX_OUTSTANDING)
    ) u_credit (
        .clk_i  (clk),
        .rst_ni (reset_n),
        .inc_i  (burst_first),
        .dec_i  (wr_writeresponsevalid),
        .full_o (credit_full),
        .empty_o(credit_empty)
    );

    assign line_word     = seed_q + 64'(lines_q);
    assign wr_address    = addr_q;
    assign wr_burstcount = cur_len;
    assign wr_writedata  = {(DATA_WIDTH / LaneWidth){line_word}};
    assign wr_byteenable = '1;

    assign busy          = (state_q == StIssue) || (state_q == StDrain);
    assign done          = (state_q == StDone);
    assign error         = error_q;
    assign lines_written = lines_q;

endmodule

// File: tb/tb_avalon_line_writer.sv
// Directed and randomised bench for avalon_line_writer, checked against a line-level model.
module tb_avalon_line_writer;
    import avalon_line_writer_pkg::*;

    localparam int unsigned AW  = 42;
    localparam int unsigned DW  = 512;
    localparam int unsigned MB  = 4;
    localparam int unsigned MO  = 8;
    localparam int unsigned BCW = $clog2(MB) + 1;

    logic           clk = 1'b0;
    logic           reset_n = 1'b0;
    logic           start = 1'b0;
    logic [AW-1:0]  start_addr = '0;
    logic [15:0]    num_lines = '0;
    logic [63:0]    seed = '0;
    logic           busy, done, error;
    logic [15:0]    lines_written;
    logic           wr_write;
    logic [AW-1:0]  wr_address;
    logic [BCW-1:0] wr_burstcount;
    logic [DW-1:0]  wr_writedata;
    logic [DW/8-1:0] wr_byteenable;
    logic           wr_waitrequest = 1'b0;
    logic           wr_writeresponsevalid = 1'b0;
    logic [1:0]     wr_writeresponse = 2'b00;

    always #5 clk = ~clk;

    avalon_line_writer #(
        .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .MAX_BURST(MB), .MAX_OUTSTANDING(MO)
    ) dut (
        .clk                  (clk),
        .reset_n              (reset_n),
        .start                (start),
        .start_addr           (start_addr),
        .num_lines            (num_lines),
        .seed                 (seed),
        .busy                 (busy),
        .done                 (done),
        .error                (error),
        .lines_written        (lines_written),
        .wr_write             (wr_write),
        .wr_address           (wr_address),
        .wr_burstcount        (wr_burstcount),
        .wr_writedata         (wr_writedata),
        .wr_byteenable        (wr_byteenable),
        .wr_waitrequest       (wr_waitrequest),
        .wr_writeresponsevalid(wr_writeresponsevalid),
        .wr_writeresponse     (wr_writeresponse)
    );

    int tests = 0;
    int fails = 0;

    // Bus monitor: logs every accepted beat and counts protocol violations.
    logic [AW-1:0]  mon_addr [$];
    logic [BCW-1:0] mon_bc   [$];
    logic [DW-1:0]  mon_data [$];
    int             bursts_seen = 0;
    int             stab_viol = 0;
    int             burst_viol = 0;
    int             be_viol = 0;
    int             mon_left = 0;
    logic           mon_stall = 1'b0;
    logic [AW-1:0]  mon_pa;
    logic [BCW-1:0] mon_pb;
    logic [DW-1:0]  mon_pd;

    initial begin : monitor
        forever begin
            @(negedge clk);
            if (!reset_n) begin
                mon_left  = 0;
                mon_stall = 1'b0;
            end else begin
                if (mon_stall && (wr_write !== 1'b1 || wr_address !== mon_pa ||
                                  wr_burstcount !== mon_pb || wr_writedata !== mon_pd))
                    stab_viol++;
                if (mon_left > 0 && wr_write !== 1'b1) burst_viol++;
                if (wr_write === 1'b1 && wr_byteenable !== '1) be_viol++;
                mon_stall = (wr_write === 1'b1) && wr_waitrequest;
                mon_pa = wr_address;
                mon_pb = wr_burstcount;
                mon_pd = wr_writedata;
                if (wr_write === 1'b1 && !wr_waitrequest) begin
                    mon_addr.push_back(wr_address);
                    mon_bc.push_back(wr_burstcount);
                    mon_data.push_back(wr_writedata);
                    if (mon_left <= 0) mon_left = int'(wr_burstcount);
                    mon_left--;
                    if (mon_left == 0) bursts_seen++;
                end
            end
        end
    end

    // Responder / stimulus knobs, owned by the main block.
    int responded = 0;
    int hold = 0;
    int release_n = 0;
    int bad_n = 0;
    int wait_pct = 0;
    int resp_pct = 100;
    int force_wait = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_wide(input string tag, input logic [DW-1:0] obs,
                              input logic [DW-1:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One clock: drive responses and waitrequest just after the edge.
    task automatic tick();
        @(posedge clk);
        #1;
        start = 1'b0;
        wr_writeresponsevalid = 1'b0;
        wr_writeresponse = RespOkay;
        if (bursts_seen > responded && (hold == 0 || release_n > 0) &&
            int'($urandom_range(99, 0)) < resp_pct) begin
            wr_writeresponsevalid = 1'b1;
            if (bad_n > 0) begin
                wr_writeresponse = RespSlaveErr;
                bad_n--;
            end
            responded++;
            if (hold != 0) release_n--;
        end
        if (force_wait > 0) begin
            wr_waitrequest = 1'b1;
            force_wait--;
        end else begin
            wr_waitrequest = (int'($urandom_range(99, 0)) < wait_pct);
        end
    endtask

    task automatic launch(input logic [AW-1:0] a, input int n, input logic [63:0] s);
        tick();
        start = 1'b1;
        start_addr = a;
        num_lines = 16'(n);
        seed = s;
    endtask

    task automatic finish_job(input string tag, output logic err_at_done);
        int cnt = 0;
        do begin
            tick();
            cnt++;
        end while (done !== 1'b1 && cnt < 3000);
        check({tag, " done"}, 64'(done), 64'(1));
        err_at_done = error;
        check({tag, " busy at done"}, 64'(busy), 64'(0));
        tick();
        check({tag, " done one cycle"}, 64'(done), 64'(0));
    endtask

    // Line-level model: line i lands in burst i/MB at a+MB*(i/MB), data = seed+i in every lane.
    task automatic check_beats(input string tag, input int base, input logic [AW-1:0] a,
                               input int n, input logic [63:0] s);
        int f0 = fails;
        check({tag, " beats"}, 64'(mon_data.size() - base), 64'(n));
        for (int i = 0; i < n && base + i < mon_data.size(); i++) begin
            int            bstart = (i / int'(MB)) * int'(MB);
            int            elen = (n - bstart < int'(MB)) ? n - bstart : int'(MB);
            logic [AW-1:0] ea = a + AW'(bstart);
            logic [63:0]   w = s + 64'(i);
            logic [DW-1:0] ed = {(DW / 64){w}};
            check({tag, " addr"}, 64'(mon_addr[base + i]), 64'(ea));
            check({tag, " burstcount"}, 64'(mon_bc[base + i]), 64'(elen));
            check_wide({tag, " data"}, mon_data[base + i], ed);
            if (fails > f0) break;
        end
    endtask

    initial begin : main
        logic          e;
        int            base, bb, mark, done_cnt, tmo, n;
        logic [AW-1:0] a;
        logic [63:0]   s;

        // Reset state
        repeat (3) tick();
        check("rst wr_write", 64'(wr_write), 64'(0));
        check("rst busy", 64'(busy), 64'(0));
        check("rst done", 64'(done), 64'(0));
        check("rst error", 64'(error), 64'(0));
        check("rst lines_written", 64'(lines_written), 64'(0));
        reset_n = 1'b1;
        tick();

        // Single line
        base = mon_data.size();
        bb = bursts_seen;
        launch(AW'(64'h1000), 1, 64'h48);
        finish_job("single", e);
        check_beats("single", base, AW'(64'h1000), 1, 64'h48);
        check("single bursts", 64'(bursts_seen - bb), 64'(1));
        check("single error", 64'(e), 64'(0));
        check("single lines_written", 64'(lines_written), 64'(1));

        // Ten lines split 4/4/2
        a = AW'({$urandom, $urandom});
        s = {$urandom, $urandom};
        base = mon_data.size();
        bb = bursts_seen;
        launch(a, 10, s);
        finish_job("ten", e);
        check_beats("ten", base, a, 10, s);
        check("ten bursts", 64'(bursts_seen - bb), 64'(3));
        check("ten lines_written", 64'(lines_written), 64'(10));

        // Five-cycle waitrequest stall in the middle of a burst
        a = AW'({$urandom, $urandom});
        s = {$urandom, $urandom};
        base = mon_data.size();
        launch(a, 8, s);
        tmo = 0;
        while (mon_data.size() < base + 2 && tmo < 50) begin
            tick();
            tmo++;
        end
        check("stall reached mid-burst", 64'(mon_data.size() - base), 64'(2));
        force_wait = 5;
        finish_job("stall", e);
        check_beats("stall", base, a, 8, s);
        check("stall stability", 64'(stab_viol), 64'(0));
        check("stall back-to-back", 64'(burst_viol), 64'(0));

        // Outstanding limit with responses withheld
        hold = 1;
        release_n = 0;
        a = AW'({$urandom, $urandom});
        s = {$urandom, $urandom};
        base = mon_data.size();
        bb = bursts_seen;
        launch(a, 40, s);
        repeat (80) tick();
        check("credit stall bursts", 64'(bursts_seen - bb), 64'(MO));
        check("credit stall busy", 64'(busy), 64'(1));
        release_n = 1;
        repeat (30) tick();
        check("credit one released", 64'(bursts_seen - bb), 64'(MO + 1));
        hold = 0;
        finish_job("credit", e);
        check_beats("credit", base, a, 40, s);
        check("credit lines_written", 64'(lines_written), 64'(40));

        // Error response sticks through done; the next start clears it
        bad_n = 1;
        base = mon_data.size();
        a = AW'({$urandom, $urandom});
        s = {$urandom, $urandom};
        launch(a, 6, s);
        finish_job("errresp", e);
        check("errresp error at done", 64'(e), 64'(1));
        check("errresp held in idle", 64'(error), 64'(1));
        check_beats("errresp", base, a, 6, s);
        launch(a, 3, s);
        tick();
        check("errresp cleared by start", 64'(error), 64'(0));
        finish_job("errclr", e);
        check("errclr error at done", 64'(e), 64'(0));

        // Stray response with nothing outstanding
        tick();
        wr_writeresponsevalid = 1'b1;
        tick();
        check("stray error", 64'(error), 64'(1));
        base = mon_data.size();
        a = AW'({$urandom, $urandom});
        s = {$urandom, $urandom};
        launch(a, 5, s);
        finish_job("after stray", e);
        check("after stray error", 64'(e), 64'(0));
        check_beats("after stray", base, a, 5, s);

        // Zero-length job
        base = mon_data.size();
        launch(a, 0, s);
        tick();
        check("zero done", 64'(done), 64'(1));
        check("zero busy", 64'(busy), 64'(0));
        tick();
        check("zero done one cycle", 64'(done), 64'(0));
        check("zero beats", 64'(mon_data.size() - base), 64'(0));
        check("zero lines_written", 64'(lines_written), 64'(0));

        // Reset at the third beat of eight
        base = mon_data.size();
        launch(AW'({$urandom, $urandom}), 8, {$urandom, $urandom});
        tmo = 0;
        while (mon_data.size() < base + 2 && tmo < 50) begin
            tick();
            tmo++;
        end
        check("abort write before reset", 64'(wr_write), 64'(1));
        reset_n = 1'b0;
        #1;
        check("abort write async", 64'(wr_write), 64'(0));
        check("abort busy async", 64'(busy), 64'(0));
        tick();
        tick();
        check("abort lines_written", 64'(lines_written), 64'(0));
        check("abort error", 64'(error), 64'(0));
        reset_n = 1'b1;
        responded = bursts_seen;
        mark = mon_data.size();
        done_cnt = 0;
        repeat (20) begin
            tick();
            if (done === 1'b1) done_cnt++;
        end
        check("abort no done", 64'(done_cnt), 64'(0));
        check("abort no beats", 64'(mon_data.size() - mark), 64'(0));
        check("abort idle", 64'(busy), 64'(0));

        // Randomised jobs with backpressure, slow responses and ignored restarts
        wait_pct = 25;
        resp_pct = 40;
        for (int j = 0; j < 8; j++) begin
            n = int'($urandom_range(30, 1));
            a = AW'({$urandom, $urandom});
            s = (j == 0) ? 64'hFFFF_FFFF_FFFF_FFF8 : {$urandom, $urandom};
            base = mon_data.size();
            bb = bursts_seen;
            launch(a, n, s);
            repeat (3) tick();
            if (busy === 1'b1) begin
                start = 1'b1;
                start_addr = AW'({$urandom, $urandom});
                num_lines = 16'($urandom_range(40, 1));
                seed = {$urandom, $urandom};
            end
            finish_job("random", e);
            check_beats("random", base, a, n, s);
            check("random bursts", 64'(bursts_seen - bb), 64'((n + int'(MB) - 1) / int'(MB)));
            check("random lines_written", 64'(lines_written), 64'(n));
            check("random error", 64'(e), 64'(0));
        end

        check("global stability", 64'(stab_viol), 64'(0));
        check("global back-to-back", 64'(burst_viol), 64'(0));
        check("global byteenable", 64'(be_viol), 64'(0));

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
